// File: rtl/cic_pkg.sv
// cic_pkg: shared helpers for the CIC decimator (and future interpolator).
//   acc_width  - register width needed for lossless modular CIC arithmetic
//   round_sat  - round half up, drop LSBs, clamp to a signed output range
package cic_pkg;

  function automatic int acc_width(input int n_in, input int order, input int log2_r);
    return n_in + order * log2_r;
  endfunction

  // x is the sign-extended accumulator value. The result fits in out_w bits
  // and is returned sign-extended to 64 bits. drop must be at least 1.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] x,
                                                   input int drop, input int out_w);
    logic signed [63:0] sum, shr, hi, lo;
    sum = x + (64'sd1 <<< (drop - 1));
    shr = sum >>> drop;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (shr > hi)      return hi;
    else if (shr < lo) return lo;
    else               return shr;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one registered comb (differentiator, M=1) section.
//   clk, reset      - clock, synchronous active-high reset
//   in, token_in    - decimated value and its qualifier
//   out, token_out  - difference in - previous(in), qualifier delayed one cycle
// The delay register only advances when a token passes, so the stage runs at
// the decimated rate while the pipeline itself is clocked every cycle.
module cic_comb_stage #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in,
  input  logic         token_in,
  output logic [W-1:0] out,
  output logic         token_out
);

  logic [W-1:0] dly_q, out_q;
  logic         tok_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q <= '0;
      out_q <= '0;
      tok_q <= 1'b0;
    end else begin
      tok_q <= token_in;
      if (token_in) begin
        dly_q <= in;
        out_q <= in - dly_q;
      end
    end
  end

  assign out       = out_q;
  assign token_out = tok_q;

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: ORDER-stage CIC decimator by 2**LOG2_R with rounded,
// saturated output behind a valid/ready handshake.
//   CLK_3M, reset              - clock, synchronous active-high reset
//   sample_in, sample_valid    - signed input sample stream
//   out_data, out_valid        - decimated result, held until consumed
//   out_ready                  - consumer accepts out_data
//   overrun                    - sticky: an unconsumed result was overwritten
module cic_decimator
  import cic_pkg::*;
#(
  parameter int N_BITS_IN  = 9,
  parameter int ORDER      = 3,
  parameter int LOG2_R     = 6,
  parameter int N_BITS_OUT = 16
) (
  input  logic                  CLK_3M,
  input  logic                  reset,
  input  logic [N_BITS_IN-1:0]  sample_in,
  input  logic                  sample_valid,
  output logic [N_BITS_OUT-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int ACC_W = acc_width(N_BITS_IN, ORDER, LOG2_R);
  localparam int DROP  = ACC_W - N_BITS_OUT;

  // ---------------- integrators ----------------
  logic [ORDER-1:0][ACC_W-1:0] integ_q, integ_d;
  logic [ACC_W-1:0]            sample_ext;

  assign sample_ext = {{(ACC_W-N_BITS_IN){sample_in[N_BITS_IN-1]}}, sample_in};

  // Each stage adds the registered value of the previous stage, so every
  // stage updates together; wrap-around is intentional and cancels in the combs.
  always_comb begin
    integ_d = integ_q;
    if (sample_valid) begin
      integ_d[0] = integ_q[0] + sample_ext;
      for (int k = 1; k < ORDER; k++)
        integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  // ---------------- decimation counter ----------------
  logic [LOG2_R-1:0] cnt_q, cnt_d;
  logic              strobe;

  assign strobe = sample_valid && (cnt_q == '1);
  assign cnt_d  = sample_valid ? cnt_q + LOG2_R'(1) : cnt_q;

  always_ff @(posedge CLK_3M) begin
    if (reset) begin
      integ_q <= '0;
      cnt_q   <= '0;
    end else begin
      integ_q <= integ_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- comb chain ----------------
  // The first comb register doubles as the capture register: it samples the
  // post-update last-integrator value on the strobe cycle.
  logic [ORDER:0][ACC_W-1:0] comb_v;
  logic [ORDER:0]            comb_tok;

  assign comb_v[0]   = integ_d[ORDER-1];
  assign comb_tok[0] = strobe;

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_comb (
      .clk       (CLK_3M),
      .reset     (reset),
      .in        (comb_v[k]),
      .token_in  (comb_tok[k]),
      .out       (comb_v[k+1]),
      .token_out (comb_tok[k+1])
    );
  end

  // ---------------- output stage ----------------
  logic [N_BITS_OUT-1:0] out_data_q, out_data_d, rounded;
  logic                  out_valid_q, out_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  new_res;

  assign new_res = comb_tok[ORDER];
  assign rounded = N_BITS_OUT'(round_sat(64'(signed'(comb_v[ORDER])), DROP, N_BITS_OUT));

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (new_res) begin
      out_data_d  = rounded;
      out_valid_d = 1'b1;
      // A same-cycle transfer consumes the old word, so that is not an overrun.
      if (out_valid_q && !out_ready) overrun_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_3M) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_decimator.sv
module tb_cic_decimator;

  logic               CLK_3M = 1'b0;
  logic               reset = 1'b0;
  logic signed [8:0]  sample_in = '0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  always #5 CLK_3M = ~CLK_3M;

  cic_decimator dut (
    .CLK_3M       (CLK_3M),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun)
  );

  // Inputs change and outputs are observed on the falling edge.
  task automatic do_reset();
    sample_valid = 1'b0;
    reset = 1'b1;
    @(negedge CLK_3M);
    @(negedge CLK_3M);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%0d overrun=%b, want 0/0/0", out_valid, out_data, overrun);
    end
  endtask

  // DC input; checks output spacing, settled value from the 4th output, count.
  task automatic run_dc(input string name, input logic signed [8:0] val, input bit toggle,
                        input int n_out, input logic signed [15:0] exp);
    int cnt, last, period;
    do_reset();
    out_ready = 1'b1;
    sample_in = val;
    cnt = 0;
    last = -1;
    period = toggle ? 128 : 64;
    for (int c = 0; c < n_out * period + 8; c++) begin
      sample_valid = toggle ? (c % 2 == 0) : 1'b1;
      @(negedge CLK_3M);
      if (out_valid === 1'b1) begin
        cnt++;
        if (last >= 0) begin
          checks++;
          if (c - last != period) begin
            errors++;
            $display("FAIL %s_period: got %0d cycles, want %0d", name, c - last, period);
          end
        end
        last = c;
        if (cnt >= 4) begin
          checks++;
          if (out_data !== exp) begin
            errors++;
            $display("FAIL %s_value: output %0d got %0d, want %0d", name, cnt, out_data, exp);
          end
        end
      end
    end
    sample_valid = 1'b0;
    checks++;
    if (cnt != n_out) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs, want %0d", name, cnt, n_out);
    end
  endtask

  task automatic test_dc();
    run_dc("dc_p1",   9'sd1,    1'b0, 8,  16'sd128);
    run_dc("dc_p255", 9'sd255,  1'b0, 40, 16'sd32640);
    run_dc("dc_m256", -9'sd256, 1'b0, 40, -16'sd32768);
  endtask

  task automatic test_toggle();
    run_dc("toggle", 9'sd1, 1'b1, 6, 16'sd128);
  endtask

  // First result from reset with DC +1 is C(64,3)=41664 -> round(41664/2048)=20.
  task automatic test_latency();
    do_reset();
    out_ready = 1'b1;
    sample_in = 9'sd1;
    for (int c = 0; c < 64; c++) begin
      sample_valid = 1'b1;
      @(negedge CLK_3M);
    end
    sample_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge CLK_3M);
      checks++;
      if (out_valid !== (k == 4)) begin
        errors++;
        $display("FAIL latency_k%0d: out_valid=%b, want %b", k, out_valid, (k == 4));
      end
    end
    checks++;
    if (out_data !== 16'sd20) begin
      errors++;
      $display("FAIL latency_data: got %0d, want 20", out_data);
    end
    @(negedge CLK_3M);
  endtask

  // Second result from reset: C(128,3)-3*C(64,3)=216384 -> 106.
  task automatic test_overrun();
    do_reset();
    out_ready = 1'b0;
    sample_in = 9'sd1;
    for (int c = 0; c < 128; c++) begin
      sample_valid = 1'b1;
      @(negedge CLK_3M);
      if (c == 66) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'sd20 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL overrun_first: valid=%b data=%0d overrun=%b, want 1/20/0", out_valid, out_data, overrun);
        end
      end
    end
    sample_valid = 1'b0;
    repeat (3) @(negedge CLK_3M);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd106 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: valid=%b data=%0d overrun=%b, want 1/106/1", out_valid, out_data, overrun);
    end
    out_ready = 1'b1;
    @(negedge CLK_3M);
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: valid=%b overrun=%b, want 0/1", out_valid, overrun);
    end
  endtask

  // Continues from the overrun state (overrun=1, out_data=106).
  task automatic test_reset_midstream();
    bit seen;
    out_ready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      sample_valid = 1'b1;
      @(negedge CLK_3M);
    end
    sample_valid = 1'b0;
    @(negedge CLK_3M);
    reset = 1'b1;
    @(negedge CLK_3M);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: valid=%b data=%0d overrun=%b, want 0/0/0", out_valid, out_data, overrun);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK_3M);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_flush: out_valid=1 after reset, want 0");
    end
    // 63 samples must not produce a result.
    out_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 63 + 8; c++) begin
      sample_valid = (c < 63);
      @(negedge CLK_3M);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_63: out_valid=1 after 63 samples, want 0");
    end
    sample_valid = 1'b1;
    @(negedge CLK_3M);
    sample_valid = 1'b0;
    repeat (3) @(negedge CLK_3M);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd20) begin
      errors++;
      $display("FAIL midreset_fresh: valid=%b data=%0d, want 1/20", out_valid, out_data);
    end
    // Next result lands on the same edge as a transfer of the held word.
    for (int c = 0; c < 64; c++) begin
      sample_valid = 1'b1;
      @(negedge CLK_3M);
    end
    sample_valid = 1'b0;
    repeat (2) @(negedge CLK_3M);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd20) begin
      errors++;
      $display("FAIL coincide_hold: valid=%b data=%0d, want 1/20", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge CLK_3M);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd106 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL coincide_load: valid=%b data=%0d overrun=%b, want 1/106/0", out_valid, out_data, overrun);
    end
    @(negedge CLK_3M);
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL coincide_drain: valid=%b overrun=%b, want 0/0", out_valid, overrun);
    end
  endtask

  initial begin
    @(negedge CLK_3M);
    test_reset();
    test_dc();
    test_toggle();
    test_latency();
    test_overrun();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
